// File: rtl/serial_pkg.sv
// serial_pkg: shared state type and default word width for the serial feeder and detector harness.
package serial_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_feeder_bit_counter.sv
// bit_counter: bit position counter with synchronous clear and rollover compare.
module bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count,
  output logic         rollover_flag
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_count <= '0;
    else if (clear) r_count <= '0;
    else if (count_enable) r_count <= r_count + 1'b1;
  assign count = r_count;
  assign rollover_flag = (r_count == rollover_val);
endmodule

// File: rtl/serial_feeder.sv
// serial_feeder: accepts parallel words on valid/ready and streams them MSB-first with no gap between words.
module serial_feeder
  import serial_pkg::*;
#(
  parameter int   DATA_WIDTH = DEFAULT_WIDTH,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  serial_out,
  output logic                  busy,
  output logic                  word_done
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  state_t r_state, w_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0] w_cnt;
  logic w_roll, w_last, w_accept;
  assign w_accept = data_valid && data_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = w_accept ? SHIFT : (w_last ? IDLE : r_state);
  always_comb begin
    busy       = (r_state == SHIFT);
    w_last     = busy && w_roll;
    data_ready = !busy || w_last;
    word_done  = w_last;
    serial_out = busy ? r_shift[DATA_WIDTH-1] : IDLE_BIT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_shift <= '0;
    else if (w_accept) r_shift <= data_in;
    else if (busy) r_shift <= r_shift << 1;
  // Clearing on the last bit keeps the count within 0..DATA_WIDTH-1 for any width.
  bit_counter #(.W(CW)) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (w_accept || w_last),
    .count_enable (busy),
    .rollover_val (LAST),
    .count        (w_cnt),
    .rollover_flag(w_roll)
  );
endmodule
